// File: rtl/cmd_packet_assembler.sv
// Command packet assembler: gathers five 32-bit command words into one
// 160-bit packet {opcode, flags, param0..param3}, reports illegal opcodes,
// optionally drops NOP packets and keeps wrapping statistics counters.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_HDR     | waiting for word0 (opcode + flags)
// ST_PARAM   | collecting param[idx], idx = 0..3
// ST_EMIT    | complete packet held on out_pkt until out_ready
module cmd_packet_assembler #(
  parameter int DROP_NOP  = 1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [31:0]          in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [159:0]         out_pkt,
  input  logic                 out_ready,
  output logic                 err_valid,
  output logic [7:0]           err_opcode,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] nop_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam logic [7:0] CMD_NOP = 8'h00;

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_PARAM = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx;
  logic [7:0]  opcode;
  logic [23:0] flags;
  logic [31:0] param0, param1, param2, param3;

  logic word_acc;
  logic pkt_acc;
  logic pkt_end;
  logic opcode_legal;
  logic opcode_drop;
  logic end_err;
  logic end_nop;

  // Handshakes: flush blocks both sides so it wins over any transfer.
  // rst_n gates in_ready so nothing is offered as accepted during reset.
  assign in_ready  = rst_n && !flush && (state != ST_EMIT);
  assign out_valid = (state == ST_EMIT) && !flush;
  assign word_acc  = in_valid && in_ready;
  assign pkt_acc   = out_valid && out_ready;
  assign pkt_end   = word_acc && (state == ST_PARAM) && (idx == 2'd3);
  assign out_pkt   = {opcode, flags, param0, param1, param2, param3};

  // Opcode classification of the latched header.
  always_comb begin
    opcode_legal = 1'b0;
    if (opcode <= 8'h0D) opcode_legal = 1'b1;
    if (opcode == 8'h10 || opcode == 8'h11 || opcode == 8'hFF) opcode_legal = 1'b1;
    opcode_drop = (DROP_NOP != 0) && (opcode == CMD_NOP);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HDR;
    else        state <= state_nxt;
  end

  // Next-state logic and packet-end classification strobes.
  always_comb begin
    state_nxt = state;
    end_err   = 1'b0;
    end_nop   = 1'b0;
    if (flush) begin
      state_nxt = ST_HDR;
    end else begin
      case (state)
        ST_HDR: begin
          if (word_acc) state_nxt = ST_PARAM;
        end
        ST_PARAM: begin
          if (pkt_end) begin
            if (!opcode_legal) begin
              end_err   = 1'b1;
              state_nxt = ST_HDR;
            end else if (opcode_drop) begin
              end_nop   = 1'b1;
              state_nxt = ST_HDR;
            end else begin
              state_nxt = ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (pkt_acc) state_nxt = ST_HDR;
        end
        default: state_nxt = ST_HDR;
      endcase
    end
  end

  // Packet field capture and parameter index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= 2'd0;
      opcode <= 8'h00;
      flags  <= 24'h0;
      param0 <= 32'h0;
      param1 <= 32'h0;
      param2 <= 32'h0;
      param3 <= 32'h0;
    end else if (word_acc) begin
      if (state == ST_HDR) begin
        opcode <= in_data[31:24];
        flags  <= in_data[23:0];
        idx    <= 2'd0;
      end else begin
        case (idx)
          2'd0:    param0 <= in_data;
          2'd1:    param1 <= in_data;
          2'd2:    param2 <= in_data;
          default: param3 <= in_data;
        endcase
        idx <= idx + 2'd1;
      end
    end
  end

  // Error reporting: one-cycle pulse, opcode held until the next pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid  <= 1'b0;
      err_opcode <= 8'h00;
    end else begin
      err_valid <= end_err;
      if (end_err) err_opcode <= opcode;
    end
  end

  // Statistics counters, wrapping naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
      nop_count <= '0;
      err_count <= '0;
    end else begin
      if (pkt_acc) pkt_count <= pkt_count + CNT_WIDTH'(1);
      if (end_nop) nop_count <= nop_count + CNT_WIDTH'(1);
      if (end_err) err_count <= err_count + CNT_WIDTH'(1);
    end
  end

endmodule
